mem_stage: RTL and testbench

Memory-access pipeline stage placed directly after EX. It latches the EX→MEM payload and completes loads and stores by waiting for `data_sram_data_ok_i`. It aligns and sign/zero-extends load data and hands results to WB under the valid/allowin handshake. It also drives the forward bus and the exception-hold signal that EX consumes as `mem_to_ibus`, and it discards in-flight SRAM responses that belong to flushed instructions.

---
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
// Latches the EX payload, waits for data-SRAM data_ok on loads/stores,
// aligns and extends load data, drives WB handshake and the forward bus,
// and discards SRAM responses that belong to flushed instructions.
// Optional feature macro: MEM_RDATA_BYPASS_EN (data_ok-cycle rdata goes
// straight to WB/forward; when undefined, rdata is registered first).
module mem_stage #(
   parameter int unsigned CANCEL_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_to_mem_valid_i,
   output logic        mem_allowin_o,
   input  logic        ex_mem_req_i,
   input  logic        ex_is_load_i,
   input  logic [2:0]  ex_load_op_i,
   input  logic [1:0]  ex_addr_low2_i,
   input  logic        ex_regs_we_i,
   input  logic [4:0]  ex_regs_waddr_i,
   input  logic [31:0] ex_regs_wdata_i,
   input  logic [31:0] ex_pc_i,
   input  logic        ex_excep_en_i,
   input  logic        data_sram_data_ok_i,
   input  logic [31:0] data_sram_rdata_i,
   input  logic        excep_flush_i,
   input  logic        wb_allowin_i,
   output logic        mem_to_wb_valid_o,
   output logic [31:0] wb_pc_o,
   output logic        wb_regs_we_o,
   output logic [4:0]  wb_regs_waddr_o,
   output logic [31:0] wb_regs_wdata_o,
   output logic        wb_excep_en_o,
   output logic        fwd_we_o,
   output logic [4:0]  fwd_waddr_o,
   output logic [31:0] fwd_wdata_o,
   output logic        fwd_stall_o,
   output logic        mem_excep_o
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OP_W  = 3;
   localparam logic [CANCEL_W-1:0] CANCEL_MAX = {CANCEL_W{1'b1}};

   localparam logic [OP_W-1:0] OP_LD_B  = 3'b000;
   localparam logic [OP_W-1:0] OP_LD_H  = 3'b001;
   localparam logic [OP_W-1:0] OP_LD_W  = 3'b010;
   localparam logic [OP_W-1:0] OP_LD_BU = 3'b100;
   localparam logic [OP_W-1:0] OP_LD_HU = 3'b101;

   // Per-entry state: EMPTY (no instruction), WAIT (data_ok outstanding),
   // READY (result available, either no access or response captured).
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_t;

   typedef struct packed {
      logic              is_load;
      logic [OP_W-1:0]   load_op;
      logic [1:0]        addr_low2;
      logic              regs_we;
      logic [REG_W-1:0]  regs_waddr;
      logic [XLEN-1:0]   regs_wdata;
      logic [XLEN-1:0]   pc;
      logic              excep_en;
   } payload_t;

   state_t              state_q;
   state_t              state_d;
   payload_t            ent_q;
   payload_t            ent_new;
   logic [XLEN-1:0]     rdata_buf_q;
   logic [CANCEL_W-1:0] cancel_q;
   logic [CANCEL_W-1:0] cancel_d;

   logic            valid;
   logic            hit;
   logic            wait_hit;
   logic            ready_go;
   logic            load_en;
   logic            handoff;
   logic            cancel_inc;
   logic            cancel_dec;
   logic [XLEN-1:0] load_src;
   logic [XLEN-1:0] load_shift;
   logic [XLEN-1:0] load_ext;

   // Handshake terms; a response only counts as ours when nothing is pending discard.
   always_comb begin
      valid    = (state_q != S_EMPTY);
      hit      = data_sram_data_ok_i & (cancel_q == '0);
      wait_hit = (state_q == S_WAIT) & hit;
`ifdef MEM_RDATA_BYPASS_EN
      ready_go = (state_q == S_READY) | wait_hit;
      load_src = wait_hit ? data_sram_rdata_i : rdata_buf_q;
`else
      ready_go = (state_q == S_READY);
      load_src = rdata_buf_q;
`endif
      mem_allowin_o     = ~valid | (ready_go & wb_allowin_i);
      mem_to_wb_valid_o = valid & ready_go & ~excep_flush_i;
      load_en           = mem_allowin_o & ex_to_mem_valid_i & ~excep_flush_i;
      handoff           = mem_to_wb_valid_o & wb_allowin_i;
   end

   // Next entry state: flush kills, a new entry replaces, hand-off empties, hit completes.
   always_comb begin
      state_d = state_q;
      if (excep_flush_i) begin
         state_d = S_EMPTY;
      end else if (load_en) begin
         state_d = ex_mem_req_i ? S_WAIT : S_READY;
      end else if (handoff) begin
         state_d = S_EMPTY;
      end else if (wait_hit) begin
         state_d = S_READY;
      end
   end

   // Discard counter: a request killed in WAIT leaves one response to drop.
   always_comb begin
      cancel_d   = cancel_q;
      cancel_inc = excep_flush_i & (state_q == S_WAIT) & ~hit;
      cancel_dec = data_sram_data_ok_i & (cancel_q != '0);
      if (cancel_inc & ~cancel_dec) begin
         if (cancel_q != CANCEL_MAX) begin
            cancel_d = cancel_q + CANCEL_W'(1);
         end
      end else if (cancel_dec & ~cancel_inc) begin
         cancel_d = cancel_q - CANCEL_W'(1);
      end
   end

   // Payload presented by EX this cycle.
   always_comb begin
      ent_new            = '0;
      ent_new.is_load    = ex_is_load_i;
      ent_new.load_op    = ex_load_op_i;
      ent_new.addr_low2  = ex_addr_low2_i;
      ent_new.regs_we    = ex_regs_we_i;
      ent_new.regs_waddr = ex_regs_waddr_i;
      ent_new.regs_wdata = ex_regs_wdata_i;
      ent_new.pc         = ex_pc_i;
      ent_new.excep_en   = ex_excep_en_i;
   end

   // Byte/halfword selection by offset, then sign or zero extension.
   always_comb begin
      load_shift = load_src >> {ent_q.addr_low2, 3'b000};
      load_ext   = load_src;
      case (ent_q.load_op)
         OP_LD_B:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
         OP_LD_H:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
         OP_LD_W:  load_ext = load_src;
         OP_LD_BU: load_ext = {24'h0, load_shift[7:0]};
         OP_LD_HU: load_ext = {16'h0, load_shift[15:0]};
         default:  load_ext = load_src;
      endcase
   end

   // WB and forward outputs derived from the latched entry.
   always_comb begin
      wb_pc_o         = ent_q.pc;
      wb_regs_we_o    = valid & ent_q.regs_we & ~ent_q.excep_en;
      wb_regs_waddr_o = ent_q.regs_waddr;
      wb_regs_wdata_o = ent_q.is_load ? load_ext : ent_q.regs_wdata;
      wb_excep_en_o   = valid & ent_q.excep_en;
      fwd_we_o        = wb_regs_we_o;
      fwd_waddr_o     = wb_regs_waddr_o;
      fwd_wdata_o     = wb_regs_wdata_o;
      fwd_stall_o     = valid & ent_q.is_load & ~ready_go;
      mem_excep_o     = valid & ent_q.excep_en;
   end

   // Entry state and discard counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_EMPTY;
         cancel_q <= '0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
      end
   end

   // Payload latch on acceptance from EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
      end else if (load_en) begin
         ent_q <= ent_new;
      end
   end

   // Response buffer holds the data while WB is blocked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_buf_q <= '0;
      end else if (wait_hit) begin
         rdata_buf_q <= data_sram_rdata_i;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps plus a WB scoreboard.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_to_mem_valid_i;
   logic        mem_allowin_o;
   logic        ex_mem_req_i;
   logic        ex_is_load_i;
   logic [2:0]  ex_load_op_i;
   logic [1:0]  ex_addr_low2_i;
   logic        ex_regs_we_i;
   logic [4:0]  ex_regs_waddr_i;
   logic [31:0] ex_regs_wdata_i;
   logic [31:0] ex_pc_i;
   logic        ex_excep_en_i;
   logic        data_sram_data_ok_i;
   logic [31:0] data_sram_rdata_i;
   logic        excep_flush_i;
   logic        wb_allowin_i;
   logic        mem_to_wb_valid_o;
   logic [31:0] wb_pc_o;
   logic        wb_regs_we_o;
   logic [4:0]  wb_regs_waddr_o;
   logic [31:0] wb_regs_wdata_o;
   logic        wb_excep_en_o;
   logic        fwd_we_o;
   logic [4:0]  fwd_waddr_o;
   logic [31:0] fwd_wdata_o;
   logic        fwd_stall_o;
   logic        mem_excep_o;

   typedef struct packed {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        excep;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   mem_stage dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ex_to_mem_valid_i   (ex_to_mem_valid_i),
      .mem_allowin_o       (mem_allowin_o),
      .ex_mem_req_i        (ex_mem_req_i),
      .ex_is_load_i        (ex_is_load_i),
      .ex_load_op_i        (ex_load_op_i),
      .ex_addr_low2_i      (ex_addr_low2_i),
      .ex_regs_we_i        (ex_regs_we_i),
      .ex_regs_waddr_i     (ex_regs_waddr_i),
      .ex_regs_wdata_i     (ex_regs_wdata_i),
      .ex_pc_i             (ex_pc_i),
      .ex_excep_en_i       (ex_excep_en_i),
      .data_sram_data_ok_i (data_sram_data_ok_i),
      .data_sram_rdata_i   (data_sram_rdata_i),
      .excep_flush_i       (excep_flush_i),
      .wb_allowin_i        (wb_allowin_i),
      .mem_to_wb_valid_o   (mem_to_wb_valid_o),
      .wb_pc_o             (wb_pc_o),
      .wb_regs_we_o        (wb_regs_we_o),
      .wb_regs_waddr_o     (wb_regs_waddr_o),
      .wb_regs_wdata_o     (wb_regs_wdata_o),
      .wb_excep_en_o       (wb_excep_en_o),
      .fwd_we_o            (fwd_we_o),
      .fwd_waddr_o         (fwd_waddr_o),
      .fwd_wdata_o         (fwd_wdata_o),
      .fwd_stall_o         (fwd_stall_o),
      .mem_excep_o         (mem_excep_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic drive_entry(input logic req, input logic is_load, input logic [2:0] op,
                              input logic [1:0] low2, input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic [31:0] pc, input logic excep);
      ex_to_mem_valid_i = 1'b1;
      ex_mem_req_i      = req;
      ex_is_load_i      = is_load;
      ex_load_op_i      = op;
      ex_addr_low2_i    = low2;
      ex_regs_we_i      = we;
      ex_regs_waddr_i   = waddr;
      ex_regs_wdata_i   = wdata;
      ex_pc_i           = pc;
      ex_excep_en_i     = excep;
   endtask

   task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic excep);
      exp_t e;
      e.pc = pc; e.we = we; e.waddr = waddr; e.wdata = wdata; e.excep = excep;
      sb.push_back(e);
   endtask

   // Load with data_ok one cycle after entry; the scoreboard checks the result.
   task automatic do_load(input logic [2:0] op, input logic [1:0] low2, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic [31:0] pc, input logic [4:0] waddr);
      drive_entry(1'b1, 1'b1, op, low2, 1'b1, waddr, 32'h0, pc, 1'b0);
      push(pc, 1'b1, waddr, exp_data, 1'b0);
      next_cycle();
      ex_to_mem_valid_i   = 1'b0;
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = rdata;
      next_cycle();
      data_sram_data_ok_i = 1'b0;
      data_sram_rdata_i   = 32'hA5A5_5A5A;
      next_cycle();
      next_cycle();
   endtask

   // Scoreboard: every accepted WB hand-off must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && mem_to_wb_valid_o && wb_allowin_i) begin
         check("wb_expected_present", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("wb_pc",    wb_pc_o, mon_e.pc);
            check("wb_we",    32'(wb_regs_we_o), 32'(mon_e.we));
            check("wb_waddr", 32'(wb_regs_waddr_o), 32'(mon_e.waddr));
            check("wb_wdata", wb_regs_wdata_o, mon_e.wdata);
            check("wb_excep", 32'(wb_excep_en_o), 32'(mon_e.excep));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      ex_to_mem_valid_i = 1'b0; ex_mem_req_i = 1'b0; ex_is_load_i = 1'b0;
      ex_load_op_i = 3'b000; ex_addr_low2_i = 2'b00; ex_regs_we_i = 1'b0;
      ex_regs_waddr_i = 5'd0; ex_regs_wdata_i = 32'h0; ex_pc_i = 32'h0; ex_excep_en_i = 1'b0;
      data_sram_data_ok_i = 1'b0; data_sram_rdata_i = 32'h0;
      excep_flush_i = 1'b0; wb_allowin_i = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      at_neg();
      check("rst_allowin",   32'(mem_allowin_o), 32'd1);
      check("rst_valid",     32'(mem_to_wb_valid_o), 32'd0);
      check("rst_we",        32'(wb_regs_we_o), 32'd0);
      check("rst_wdata",     wb_regs_wdata_o, 32'h0);
      check("rst_pc",        wb_pc_o, 32'h0);
      check("rst_stall",     32'(fwd_stall_o), 32'd0);
      check("rst_excep",     32'(mem_excep_o), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Non-memory instruction: one cycle in MEM
      drive_entry(1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 5'd3, 32'h0000_1234, 32'h100, 1'b0);
      push(32'h100, 1'b1, 5'd3, 32'h0000_1234, 1'b0);
      next_cycle();
      ex_to_mem_valid_i = 1'b0;
      at_neg();
      check("add_valid", 32'(mem_to_wb_valid_o), 32'd1);
      check("add_wdata", wb_regs_wdata_o, 32'h0000_1234);
      check("add_stall", 32'(fwd_stall_o), 32'd0);
      check("add_fwd_we", 32'(fwd_we_o), 32'd1);
      check("add_fwd_waddr", 32'(fwd_waddr_o), 32'd3);
      check("add_fwd_wdata", fwd_wdata_o, 32'h0000_1234);
      next_cycle();
      at_neg();
      check("add_drained", 32'(mem_to_wb_valid_o), 32'd0);

      // ld.b offset 3, data_ok two cycles after entry
      drive_entry(1'b1, 1'b1, 3'b000, 2'd3, 1'b1, 5'd5, 32'h0, 32'h104, 1'b0);
      push(32'h104, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0);
      next_cycle();
      ex_to_mem_valid_i = 1'b0;
      at_neg();
      check("ldb_stall_w0", 32'(fwd_stall_o), 32'd1);
      check("ldb_valid_w0", 32'(mem_to_wb_valid_o), 32'd0);
      next_cycle();
      at_neg();
      check("ldb_stall_w1", 32'(fwd_stall_o), 32'd1);
      next_cycle();
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = 32'h80FF_FF00;
      at_neg();
`ifdef MEM_RDATA_BYPASS_EN
      check("ldb_valid_ok", 32'(mem_to_wb_valid_o), 32'd1);
      check("ldb_wdata_ok", wb_regs_wdata_o, 32'hFFFF_FF80);
      check("ldb_stall_ok", 32'(fwd_stall_o), 32'd0);
`else
      check("ldb_valid_ok", 32'(mem_to_wb_valid_o), 32'd0);
      check("ldb_stall_ok", 32'(fwd_stall_o), 32'd1);
`endif
      next_cycle();
      data_sram_data_ok_i = 1'b0;
      data_sram_rdata_i   = 32'h0;
      at_neg();
`ifdef MEM_RDATA_BYPASS_EN
      check("ldb_valid_after", 32'(mem_to_wb_valid_o), 32'd0);
`else
      check("ldb_valid_buf", 32'(mem_to_wb_valid_o), 32'd1);
      check("ldb_wdata_buf", wb_regs_wdata_o, 32'hFFFF_FF80);
      check("ldb_stall_buf", 32'(fwd_stall_o), 32'd0);
`endif
      next_cycle();
      at_neg();
      check("ldb_drained", 32'(mem_to_wb_valid_o), 32'd0);

      // ld.hu offset 2 with WB blocked for three cycles from data_ok
      drive_entry(1'b1, 1'b1, 3'b101, 2'd2, 1'b1, 5'd6, 32'h0, 32'h108, 1'b0);
      push(32'h108, 1'b1, 5'd6, 32'h0000_8001, 1'b0);
      next_cycle();
      ex_to_mem_valid_i   = 1'b0;
      wb_allowin_i        = 1'b0;
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = 32'h8001_0000;
      at_neg();
      check("ldhu_allowin_blk", 32'(mem_allowin_o), 32'd0);
`ifdef MEM_RDATA_BYPASS_EN
      check("ldhu_valid_ok", 32'(mem_to_wb_valid_o), 32'd1);
`else
      check("ldhu_valid_ok", 32'(mem_to_wb_valid_o), 32'd0);
`endif
      next_cycle();
      data_sram_data_ok_i = 1'b0;
      data_sram_rdata_i   = 32'hFFFF_FFFF;
      at_neg();
      check("ldhu_hold1_valid", 32'(mem_to_wb_valid_o), 32'd1);
      check("ldhu_hold1_wdata", wb_regs_wdata_o, 32'h0000_8001);
      next_cycle();
      at_neg();
      check("ldhu_hold2_wdata", wb_regs_wdata_o, 32'h0000_8001);
      check("ldhu_hold2_allowin", 32'(mem_allowin_o), 32'd0);
      next_cycle();
      wb_allowin_i = 1'b1;
      at_neg();
      check("ldhu_rel_valid", 32'(mem_to_wb_valid_o), 32'd1);
      check("ldhu_rel_wdata", wb_regs_wdata_o, 32'h0000_8001);
      next_cycle();
      at_neg();
      check("ldhu_once", 32'(mem_to_wb_valid_o), 32'd0);

      // Flush during WAIT; the next load must skip the stale response
      drive_entry(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 5'd7, 32'h0, 32'h10C, 1'b0);
      next_cycle();
      ex_to_mem_valid_i = 1'b0;
      at_neg();
      check("fl_stall", 32'(fwd_stall_o), 32'd1);
      next_cycle();
      excep_flush_i = 1'b1;
      at_neg();
      check("fl_valid_gated", 32'(mem_to_wb_valid_o), 32'd0);
      next_cycle();
      excep_flush_i = 1'b0;
      drive_entry(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 5'd8, 32'h0, 32'h110, 1'b0);
      push(32'h110, 1'b1, 5'd8, 32'h0000_0BEE, 1'b0);
      at_neg();
      check("fl_allowin", 32'(mem_allowin_o), 32'd1);
      check("fl_cancel_one", 32'(dut.cancel_q), 32'd1);
      next_cycle();
      ex_to_mem_valid_i   = 1'b0;
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = 32'h0000_DEAD;
      at_neg();
      check("fl_discard_valid", 32'(mem_to_wb_valid_o), 32'd0);
      check("fl_discard_stall", 32'(fwd_stall_o), 32'd1);
      next_cycle();
      data_sram_rdata_i = 32'h0000_0BEE;
      at_neg();
      check("fl_cancel_zero", 32'(dut.cancel_q), 32'd0);
`ifdef MEM_RDATA_BYPASS_EN
      check("fl_valid_ok", 32'(mem_to_wb_valid_o), 32'd1);
      check("fl_wdata_ok", wb_regs_wdata_o, 32'h0000_0BEE);
`endif
      next_cycle();
      data_sram_data_ok_i = 1'b0;
      data_sram_rdata_i   = 32'h0;
      at_neg();
`ifndef MEM_RDATA_BYPASS_EN
      check("fl_valid_buf", 32'(mem_to_wb_valid_o), 32'd1);
      check("fl_wdata_buf", wb_regs_wdata_o, 32'h0000_0BEE);
`endif
      next_cycle();
      next_cycle();

      // Exception-carrying entry suppresses the register write
      drive_entry(1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 5'd9, 32'h0000_0055, 32'h114, 1'b1);
      push(32'h114, 1'b0, 5'd9, 32'h0000_0055, 1'b1);
      next_cycle();
      ex_to_mem_valid_i = 1'b0;
      ex_excep_en_i     = 1'b0;
      at_neg();
      check("exc_mem_excep", 32'(mem_excep_o), 32'd1);
      check("exc_wb_we",     32'(wb_regs_we_o), 32'd0);
      check("exc_wb_excep",  32'(wb_excep_en_o), 32'd1);
      check("exc_fwd_we",    32'(fwd_we_o), 32'd0);
      next_cycle();
      at_neg();
      check("exc_cleared", 32'(mem_excep_o), 32'd0);

      // Store waits for data_ok and passes its ALU result
      drive_entry(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 32'h0000_0077, 32'h118, 1'b0);
      push(32'h118, 1'b0, 5'd0, 32'h0000_0077, 1'b0);
      next_cycle();
      ex_to_mem_valid_i = 1'b0;
      at_neg();
      check("st_wait_valid", 32'(mem_to_wb_valid_o), 32'd0);
      check("st_no_stall",   32'(fwd_stall_o), 32'd0);
      next_cycle();
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = 32'h1234_5678;
      next_cycle();
      data_sram_data_ok_i = 1'b0;
      next_cycle();
      next_cycle();

      // Stray data_ok while empty is ignored
      data_sram_data_ok_i = 1'b1;
      at_neg();
      check("stray_valid", 32'(mem_to_wb_valid_o), 32'd0);
      next_cycle();
      data_sram_data_ok_i = 1'b0;
      at_neg();
      check("stray_cancel", 32'(dut.cancel_q), 32'd0);
      next_cycle();

      // Extension table
      do_load(3'b001, 2'd0, 32'h1234_8000, 32'hFFFF_8000, 32'h200, 5'd10);
      do_load(3'b100, 2'd1, 32'h0000_AB00, 32'h0000_00AB, 32'h204, 5'd11);
      do_load(3'b000, 2'd0, 32'h0000_007F, 32'h0000_007F, 32'h208, 5'd12);
      do_load(3'b001, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF, 32'h20C, 5'd13);
      do_load(3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h210, 5'd14);
      do_load(3'b100, 2'd3, 32'hFE00_0000, 32'h0000_00FE, 32'h214, 5'd15);

      // Flush coinciding with the hit: the response dies with the entry
      drive_entry(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 5'd16, 32'h0, 32'h300, 1'b0);
      next_cycle();
      ex_to_mem_valid_i   = 1'b0;
      excep_flush_i       = 1'b1;
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = 32'h1111_1111;
      at_neg();
      check("flhit_valid", 32'(mem_to_wb_valid_o), 32'd0);
      next_cycle();
      excep_flush_i       = 1'b0;
      data_sram_data_ok_i = 1'b0;
      at_neg();
      check("flhit_cancel", 32'(dut.cancel_q), 32'd0);
      check("flhit_empty", 32'(mem_allowin_o), 32'd1);
      next_cycle();
      do_load(3'b010, 2'd0, 32'h2222_3333, 32'h2222_3333, 32'h304, 5'd17);

      // Reset in the middle of a pending discard
      drive_entry(1'b1, 1'b1, 3'b010, 2'd0, 1'b1, 5'd18, 32'h0, 32'h400, 1'b0);
      next_cycle();
      ex_to_mem_valid_i = 1'b0;
      excep_flush_i     = 1'b1;
      next_cycle();
      excep_flush_i = 1'b0;
      at_neg();
      check("rstmid_cancel_pre", 32'(dut.cancel_q), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid_cancel", 32'(dut.cancel_q), 32'd0);
      check("rstmid_allowin", 32'(mem_allowin_o), 32'd1);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      do_load(3'b000, 2'd1, 32'h0000_8100, 32'hFFFF_FF81, 32'h404, 5'd19);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
